// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared types and constants for the FIR sequencer
package fir_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_WAIT_IN = 3'd2,
    S_MAC     = 3'd3,
    S_OUT     = 3'd4,
    S_DONE    = 3'd5
  } fir_state_t;

  localparam int TAP_NUM     = 11;
  localparam int BYTE_STRIDE = 4;

  // Bit positions inside the ap_ctrl status word at 0x00.
  localparam int STAT_START = 0;
  localparam int STAT_DONE  = 1;
  localparam int STAT_IDLE  = 2;

  function automatic logic [2:0] stat_vec(input logic start, input logic done, input logic idle);
    logic [2:0] v;
    v = '0;
    v[STAT_START] = start;
    v[STAT_DONE]  = done;
    v[STAT_IDLE]  = idle;
    return v;
  endfunction

endpackage

// File: rtl/fir_ring_ctr.sv
// rtl/fir_ring_ctr.sv - modulo-N up/down counter with clear and load
// Ports: clk/rst_n (async active-low), clr (to 0), load/load_val,
//        inc/dec (wrap at N), cnt (current value).
// Priority: clr > load > inc > dec.
module fir_ring_ctr #(
  parameter int N = 11,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (inc) begin
      cnt <= (cnt == W'(N - 1)) ? '0 : cnt + 1'b1;
    end else if (dec) begin
      cnt <= (cnt == '0) ? W'(N - 1) : cnt - 1'b1;
    end
  end

endmodule

// File: rtl/fir_sched.sv
// rtl/fir_sched.sv - FIR engine sequencer: ap_ctrl, RAM clear, sample/MAC/output schedule, tap port arbitration
// Ports: ap_start_pulse/ap_done_rd/cfg_len from the register block;
//        ap_start/ap_done/ap_idle/tlast_err status; ss_* input and sm_* output
//        stream handshakes; data_* and tap_* RAM controls; cfg_tap_req/gnt
//        tap RAM mux; mac_en/mac_clr MAC datapath strobes.
module fir_sched
  import fir_pkg::*;
#(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int Tape_Num    = TAP_NUM
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   ap_start_pulse,
  input  logic                   ap_done_rd,
  input  logic [pDATA_WIDTH-1:0] cfg_len,
  output logic                   ap_start,
  output logic                   ap_done,
  output logic                   ap_idle,
  output logic                   tlast_err,
  input  logic                   ss_tvalid,
  input  logic                   ss_tlast,
  output logic                   ss_tready,
  input  logic                   sm_tready,
  output logic                   sm_tvalid,
  output logic                   sm_tlast,
  output logic                   data_EN,
  output logic                   data_WE_all,
  output logic                   data_wsel,
  output logic [pADDR_WIDTH-1:0] data_A,
  output logic                   tap_EN,
  output logic [pADDR_WIDTH-1:0] tap_A,
  input  logic                   cfg_tap_req,
  output logic                   cfg_tap_gnt,
  output logic                   mac_en,
  output logic                   mac_clr
);

  localparam int IW = $clog2(Tape_Num);
  // k runs 0..Tape_Num: one extra step drains the last read into the MAC.
  localparam int KW = $clog2(Tape_Num + 1);

  fir_state_t             state_q, state_d;
  logic [KW-1:0]          k_q, k_d;
  logic [pDATA_WIDTH-1:0] len_q, cnt_q;
  logic [2:0]             status_q;
  logic [IW-1:0]          wptr, rd_idx;
  logic                   start_go, start_zero, finish, wp_inc, rd_load, rd_dec, last;

  function automatic logic [pADDR_WIDTH-1:0] byte_addr(input logic [KW-1:0] idx);
    return pADDR_WIDTH'(idx) * pADDR_WIDTH'(BYTE_STRIDE);
  endfunction

  assign last      = (cnt_q == len_q - pDATA_WIDTH'(1));
  assign ap_start  = status_q[STAT_START];
  assign ap_done   = status_q[STAT_DONE];
  assign ap_idle   = status_q[STAT_IDLE];
  // MAC owns the tap port for its whole 12-cycle window; requests just wait.
  assign cfg_tap_gnt = cfg_tap_req && (state_q != S_MAC);

  fir_ring_ctr #(.N(Tape_Num), .W(IW)) u_wptr (
    .clk(axis_clk), .rst_n(axis_rst_n), .clr(start_go), .load(1'b0),
    .load_val('0), .inc(wp_inc), .dec(1'b0), .cnt(wptr)
  );

  // Read index walks backwards from the newest sample through the ring.
  fir_ring_ctr #(.N(Tape_Num), .W(IW)) u_ridx (
    .clk(axis_clk), .rst_n(axis_rst_n), .clr(1'b0), .load(rd_load),
    .load_val(wptr), .inc(1'b0), .dec(rd_dec), .cnt(rd_idx)
  );

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      state_q <= S_IDLE;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    ss_tready   = 1'b0;
    sm_tvalid   = 1'b0;
    sm_tlast    = 1'b0;
    data_EN     = 1'b0;
    data_WE_all = 1'b0;
    data_wsel   = 1'b0;
    data_A      = '0;
    tap_EN      = 1'b0;
    tap_A       = '0;
    mac_en      = 1'b0;
    mac_clr     = 1'b0;
    start_go    = 1'b0;
    start_zero  = 1'b0;
    finish      = 1'b0;
    wp_inc      = 1'b0;
    rd_load     = 1'b0;
    rd_dec      = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (ap_start_pulse) begin
          if (cfg_len != '0) begin
            start_go = 1'b1;
            k_d      = '0;
            state_d  = S_CLEAR;
          end else begin
            start_zero = 1'b1;
            state_d    = S_DONE;
          end
        end
      end
      S_CLEAR: begin
        data_EN     = 1'b1;
        data_WE_all = 1'b1;
        data_A      = byte_addr(k_q);
        if (k_q == KW'(Tape_Num - 1)) begin
          k_d     = '0;
          state_d = S_WAIT_IN;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      S_WAIT_IN: begin
        ss_tready = 1'b1;
        if (ss_tvalid) begin
          data_EN     = 1'b1;
          data_WE_all = 1'b1;
          data_wsel   = 1'b1;
          data_A      = byte_addr(KW'(wptr));
          rd_load     = 1'b1;
          k_d         = '0;
          state_d     = S_MAC;
        end
      end
      S_MAC: begin
        if (k_q < KW'(Tape_Num)) begin
          tap_EN  = 1'b1;
          tap_A   = byte_addr(k_q);
          data_EN = 1'b1;
          data_A  = byte_addr(KW'(rd_idx));
          rd_dec  = 1'b1;
        end
        // Reads land one cycle later, so the MAC strobe trails the address by one.
        if (k_q != '0) begin
          mac_en  = 1'b1;
          mac_clr = (k_q == KW'(1));
        end
        if (k_q == KW'(Tape_Num)) begin
          k_d     = '0;
          state_d = S_OUT;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      S_OUT: begin
        sm_tvalid = 1'b1;
        sm_tlast  = last;
        if (sm_tready) begin
          wp_inc = 1'b1;
          if (last) begin
            finish  = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_WAIT_IN;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      status_q  <= stat_vec(1'b0, 1'b0, 1'b1);
      tlast_err <= 1'b0;
      len_q     <= '0;
      cnt_q     <= '0;
    end else if (start_go) begin
      status_q  <= stat_vec(1'b1, 1'b0, 1'b0);
      tlast_err <= 1'b0;
      len_q     <= cfg_len;
      cnt_q     <= '0;
    end else if (start_zero) begin
      status_q  <= stat_vec(1'b0, 1'b1, 1'b1);
      tlast_err <= 1'b0;
      cnt_q     <= '0;
    end else begin
      if (state_q == S_WAIT_IN && ss_tvalid && (ss_tlast != last)) tlast_err <= 1'b1;
      if (wp_inc) cnt_q <= cnt_q + pDATA_WIDTH'(1);
      if (finish) status_q <= stat_vec(1'b0, 1'b1, 1'b1);
      else if (state_q == S_DONE && ap_done_rd) status_q[STAT_DONE] <= 1'b0;
    end
  end

endmodule

// File: doc/fir_sched.md
# fir_sched

Sequencer for the 11-tap FIR engine: owns ap_start/ap_done/ap_idle, zeroes the data RAM at start, and accepts AXI-Stream input samples into a circular data RAM. For each sample it schedules the 11 tap/data RAM reads and MAC strobes, then presents the result on the AXI-Stream output. It also arbitrates the tap RAM port between AXI-Lite coefficient access and the compute schedule. It sits between the AXI-Lite register block, the two bram11 instances and the MAC datapath inside fir.

## Interface
- pADDR_WIDTH, 12, RAM byte-address width
- pDATA_WIDTH, 32, sample/coef width; only used for `cfg_len`
- Tape_Num, 11, tap count and data RAM depth in words
- axis_clk  in  1  sole clock, rising edge
- axis_rst_n  in  1  reset, asynchronous, active-low
- ap_start_pulse  in  1  one-cycle strobe: AXI-Lite write of 1 to bit 0 of 0x00
- ap_done_rd  in  1  one-cycle strobe: AXI-Lite read of 0x00 completed
- cfg_len  in  32  data_length register (0x10), sampled at start
- ap_start / ap_done / ap_idle  out  1  status bits 0/1/2 of 0x00
- tlast_err  out  1  sticky: ss_tlast position disagrees with cfg_len
- ss_tvalid, ss_tlast  in  1  input stream handshake/last
- ss_tready  out  1  input stream ready
- sm_tready  in  1  output stream ready
- sm_tvalid, sm_tlast  out  1  output stream valid/last
- data_EN, data_WE_all  out  1  data RAM enable; write strobe (external logic fans out to WE[3:0])
- data_wsel  out  1  write-data select: 1 = ss_tdata, 0 = zero
- data_A  out  pADDR_WIDTH  data RAM byte address (4*index)
- tap_EN  out  1  tap RAM enable for compute reads
- tap_A  out  pADDR_WIDTH  tap RAM byte address (4*k)
- cfg_tap_req  in  1  AXI-Lite requests tap RAM port
- cfg_tap_gnt  out  1  tap RAM port mux select to AXI-Lite
- mac_en, mac_clr  out  1  accumulate strobe; with mac_en, load instead of add

## Operation
- Reset values: ap_idle=1; every other output 0, addresses 0; state IDLE; wptr=0; cnt=0.
- States: IDLE → CLEAR → WAIT_IN → MAC → OUT → (WAIT_IN | DONE); DONE behaves like IDLE for start.
- IDLE/DONE: if ap_start_pulse and cfg_len≠0, latch len, ap_start=1, ap_idle=0, ap_done=0, tlast_err=0, cnt=0, wptr=0, go CLEAR. If ap_start_pulse and cfg_len=0, go DONE directly (ap_done=1). ap_start_pulse is ignored in any other state.
- CLEAR: 11 cycles writing zero to data indices 0..10 (data_wsel=0).
- WAIT_IN: ss_tready=1. On ss_tvalid&ss_tready, write ss_tdata at index wptr (data_wsel=1). If ss_tlast ≠ (cnt==len-1), set tlast_err. Go MAC.
- MAC: for k=0..10 drive tap_A=4k and data_A=4*((wptr−k) mod 11). RAM read latency is 1 cycle, so mac_en is issued for k one cycle after its address, and mac_clr is asserted with k=0's mac_en.
- OUT: sm_tvalid=1 held until sm_tready; sm_tlast=(cnt==len-1). On handshake, wptr=(wptr+1) mod 11 and cnt++. If cnt reaches len, go DONE with ap_start=0, ap_done=1, ap_idle=1; otherwise go WAIT_IN.
- ap_done is sticky; cleared by ap_done_rd only while in DONE, or by the next start.
- Tap arbitration: cfg_tap_gnt = cfg_tap_req when state ≠ MAC. During MAC the request waits, with no starvation because MAC lasts 12 cycles. When granted, tap_EN=0.
- Data RAM is never granted to AXI-Lite.

## Timing
- Input handshake at cycle T: addresses for k=0..10 at T+1..T+11; mac_en at T+2..T+12; sm_tvalid rises at T+13.
- Throughput: one sample per 14 cycles minimum.
- ss_tready is deasserted from the cycle after the handshake until OUT completes.
- Simultaneous cfg_tap_req and MAC entry: MAC wins.
- Async reset mid-run: all outputs return to reset values immediately. RAM contents are undefined; the next start re-clears the data RAM.

## Structure
- Shared package fir_pkg: state enum, TAP_NUM=11, RAM byte-stride 4, status bit positions (START=0, DONE=1, IDLE=2).
- One sub-module: fir_ring_ctr, a mod-Tape_Num up/down counter used for wptr and the read index.

## Test plan
- Reset, then poll: ap_idle=1, ap_done=0, ss_tready=0, sm_tvalid=0.
- cfg_len=3, start, feed samples 1,2,3 (tlast on the 3rd) -> exactly 11 zero writes first; three outputs, sm_tlast only on the 3rd; then ap_done=1, ap_idle=1; ap_done_rd clears ap_done.
- Single sample at cycle T with sm_tready=1 -> data_A sequence for wptr=0 is 0,40,36,…,4; mac_clr only at T+2; sm_tvalid at T+13.
- 14 samples -> wptr wraps after index 10; sample 12 is written at index 0 and its k=1 read is 40.
- cfg_tap_req held from the cycle MAC begins -> cfg_tap_gnt stays 0 for 12 cycles, then asserts in OUT.
- Early tlast on sample 2 with cfg_len=5 -> tlast_err=1, run continues to 5 outputs. Separately, assert reset during MAC -> all outputs return to reset values.
